// File: rtl/wb_drain_queue.sv
// rtl/wb_drain_queue.sv - writeback buffer draining up to two results per cycle to the RF
// and releasing write names back to the RF in allocation order.
module wb_drain_queue #(
  parameter int name_width = 1,
  parameter int data_width = 1,
  parameter int depth      = 4,
  parameter int cnt_width  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [name_width-1:0] ENQ_NAME,
  input  logic [data_width-1:0] ENQ_DATA,
  input  logic                  ENQ_E,
  output logic                  ENQ_READY,
  input  logic                  DRAIN_EN,
  output logic [name_width-1:0] WNAME_1,
  output logic [data_width-1:0] WDATA_1,
  output logic                  WE_1,
  output logic [name_width-1:0] WNAME_2,
  output logic [data_width-1:0] WDATA_2,
  output logic                  WE_2,
  output logic [name_width-1:0] FREE_NAME,
  output logic                  FREE_E,
  input  logic                  FREE_READY,
  output logic [cnt_width-1:0]  COUNT,
  output logic                  ERR
);
  localparam int num_names = 1 << name_width;
  localparam int ptr_width = $clog2(depth);

  logic [name_width-1:0] name_mem [depth];
  logic [data_width-1:0] data_mem [depth];
  logic [ptr_width-1:0]  head, tail, head_p1;
  logic [cnt_width-1:0]  count, drain_cnt;
  logic [name_width-1:0] owner;
  logic [num_names-1:0]  pending, written, pending_nxt, written_nxt;
  logic                  err;
  logic                  enq_fire, enq_bad, free_fire;

  assign head_p1   = head + ptr_width'(1);
  assign ENQ_READY = (count != cnt_width'(depth));
  assign enq_fire  = ENQ_E && ENQ_READY;
  assign enq_bad   = ENQ_E && (!ENQ_READY || pending[ENQ_NAME] || written[ENQ_NAME]);

  assign WE_1    = DRAIN_EN && (count != '0);
  assign WE_2    = DRAIN_EN && (count > cnt_width'(1));
  assign WNAME_1 = name_mem[head];
  assign WDATA_1 = data_mem[head];
  assign WNAME_2 = name_mem[head_p1];
  assign WDATA_2 = data_mem[head_p1];
  assign drain_cnt = cnt_width'(WE_1) + cnt_width'(WE_2);

  assign FREE_NAME = owner;
  assign FREE_E    = written[owner];
  assign free_fire = FREE_E && FREE_READY;

  assign COUNT = count;
  assign ERR   = err;

  // Sets win over clears: a drain re-marks a name the free port clears, and a
  // re-enqueue re-marks a name being drained; both only arise from duplicate names.
  always_comb begin
    pending_nxt = pending;
    written_nxt = written;
    if (free_fire) written_nxt[owner] = 1'b0;
    if (WE_1) begin
      pending_nxt[WNAME_1] = 1'b0;
      written_nxt[WNAME_1] = 1'b1;
    end
    if (WE_2) begin
      pending_nxt[WNAME_2] = 1'b0;
      written_nxt[WNAME_2] = 1'b1;
    end
    if (enq_fire) pending_nxt[ENQ_NAME] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      owner   <= '0;
      pending <= '0;
      written <= '0;
      err     <= 1'b0;
    end else begin
      if (enq_fire) tail <= tail + ptr_width'(1);
      head    <= head + ptr_width'(WE_1) + ptr_width'(WE_2);
      count   <= count + cnt_width'(enq_fire) - drain_cnt;
      if (free_fire) owner <= owner + name_width'(1);
      pending <= pending_nxt;
      written <= written_nxt;
      if (enq_bad) err <= 1'b1;
    end
  end

  // Entry storage needs no reset; head/tail/count define which entries are live.
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      name_mem[tail] <= ENQ_NAME;
      data_mem[tail] <= ENQ_DATA;
    end
  end

endmodule

// File: tb/tb_wb_drain_queue.sv
// tb/tb_wb_drain_queue.sv - self-checking bench for wb_drain_queue against a queue-based
// reference model.
module tb_wb_drain_queue;
  localparam int NW  = 2;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 3;
  localparam int NN  = 1 << NW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NW-1:0] ENQ_NAME;
  logic [DW-1:0] ENQ_DATA;
  logic          ENQ_E;
  logic          ENQ_READY;
  logic          DRAIN_EN;
  logic [NW-1:0] WNAME_1, WNAME_2, FREE_NAME;
  logic [DW-1:0] WDATA_1, WDATA_2;
  logic          WE_1, WE_2, FREE_E, FREE_READY, ERR;
  logic [CW-1:0] COUNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NW-1:0] name;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  bit [NN-1:0]   m_pend, m_wr;
  int            m_owner;
  bit            m_err;

  wb_drain_queue #(.name_width(NW), .data_width(DW), .depth(DEP), .cnt_width(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ENQ_NAME(ENQ_NAME), .ENQ_DATA(ENQ_DATA), .ENQ_E(ENQ_E), .ENQ_READY(ENQ_READY),
    .DRAIN_EN(DRAIN_EN),
    .WNAME_1(WNAME_1), .WDATA_1(WDATA_1), .WE_1(WE_1),
    .WNAME_2(WNAME_2), .WDATA_2(WDATA_2), .WE_2(WE_2),
    .FREE_NAME(FREE_NAME), .FREE_E(FREE_E), .FREE_READY(FREE_READY),
    .COUNT(COUNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic model_clear();
    mq.delete();
    m_pend  = '0;
    m_wr    = '0;
    m_owner = 0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ENQ_E = 1'b0; ENQ_NAME = '0; ENQ_DATA = '0; DRAIN_EN = 1'b0; FREE_READY = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
  endtask

  task automatic drive(input bit e, input logic [NW-1:0] n, input logic [DW-1:0] d,
                       input bit dr, input bit fr);
    @(negedge CLK);
    ENQ_E = e; ENQ_NAME = n; ENQ_DATA = d; DRAIN_EN = dr; FREE_READY = fr;
    #1;
  endtask

  // Advance the reference model by one cycle from the currently driven inputs, then clock.
  task automatic tick();
    bit   rdy, old_p, old_w;
    int   nd;
    ent_t e;
    rdy   = (mq.size() != DEP);
    old_p = m_pend[ENQ_NAME];
    old_w = m_wr[ENQ_NAME];
    if (m_wr[m_owner] && FREE_READY) begin
      m_wr[m_owner] = 1'b0;
      m_owner = (m_owner + 1) % NN;
    end
    nd = DRAIN_EN ? ((mq.size() < 2) ? mq.size() : 2) : 0;
    repeat (nd) begin
      e = mq.pop_front();
      m_pend[e.name] = 1'b0;
      m_wr[e.name]   = 1'b1;
    end
    if (ENQ_E) begin
      if (!rdy || old_p || old_w) m_err = 1'b1;
      if (rdy) begin
        e.name = ENQ_NAME;
        e.data = ENQ_DATA;
        mq.push_back(e);
        m_pend[ENQ_NAME] = 1'b1;
      end
    end
    @(posedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (WE_1 !== 1'b0) begin errors++; $display("FAIL reset_we1: got %b want 0", WE_1); end
    checks++; if (WE_2 !== 1'b0) begin errors++; $display("FAIL reset_we2: got %b want 0", WE_2); end
    checks++; if (FREE_E !== 1'b0) begin errors++; $display("FAIL reset_free_e: got %b want 0", FREE_E); end
    checks++; if (ENQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ENQ_READY); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
    tick();
  endtask

  task automatic test_single_drain();
    do_reset();
    drive(1'b1, 2'd1, 8'h0A, 1'b1, 1'b1);
    checks++; if (WE_1 !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", WE_1); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (WE_1 !== 1'b1) begin errors++; $display("FAIL single_we1: got %b want 1", WE_1); end
    checks++; if (WNAME_1 !== 2'd1) begin errors++; $display("FAIL single_wname1: got %0d want 1", WNAME_1); end
    checks++; if (WDATA_1 !== 8'h0A) begin errors++; $display("FAIL single_wdata1: got %h want 0a", WDATA_1); end
    checks++; if (WE_2 !== 1'b0) begin errors++; $display("FAIL single_we2: got %b want 0", WE_2); end
    checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", COUNT); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", COUNT); end
    checks++; if (FREE_E !== 1'b0) begin errors++; $display("FAIL single_free_held: got %b want 0", FREE_E); end
    tick();
  endtask

  task automatic fill_four();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, NW'(i), DW'(8'h10 + i), 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    fill_four();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (ENQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ENQ_READY); end
    checks++; if (COUNT !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", COUNT); end
    checks++; if (WE_1 !== 1'b0) begin errors++; $display("FAIL full_stall: got %b want 0", WE_1); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if ({WE_1, WE_2} !== 2'b11) begin errors++; $display("FAIL full_we_a: got %b want 11", {WE_1, WE_2}); end
    checks++; if ({WNAME_1, WNAME_2} !== {2'd0, 2'd1}) begin errors++; $display("FAIL full_names_a: got %0d,%0d want 0,1", WNAME_1, WNAME_2); end
    checks++; if (WDATA_2 !== 8'h11) begin errors++; $display("FAIL full_wdata2: got %h want 11", WDATA_2); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (ENQ_READY !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %b want 1", ENQ_READY); end
    checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL full_count2: got %0d want 2", COUNT); end
    checks++; if ({WNAME_1, WNAME_2} !== {2'd2, 2'd3}) begin errors++; $display("FAIL full_names_b: got %0d,%0d want 2,3", WNAME_1, WNAME_2); end
    checks++; if (WDATA_1 !== 8'h12) begin errors++; $display("FAIL full_wdata1_b: got %h want 12", WDATA_1); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL full_count0: got %0d want 0", COUNT); end
    tick();
  endtask

  task automatic test_full_collide();
    do_reset();
    fill_four();
    drive(1'b1, 2'd0, 8'h55, 1'b1, 1'b0);
    checks++; if (ENQ_READY !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b want 0", ENQ_READY); end
    checks++; if ({WE_1, WE_2} !== 2'b11) begin errors++; $display("FAIL collide_we: got %b want 11", {WE_1, WE_2}); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL collide_err: got %b want 1", ERR); end
    checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL collide_count: got %0d want 2", COUNT); end
    tick();
  endtask

  task automatic test_free_order();
    do_reset();
    drive(1'b1, 2'd2, 8'h22, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (FREE_E !== 1'b0) begin errors++; $display("FAIL order_hold: got %b want 0", FREE_E); end
    checks++; if (FREE_NAME !== 2'd0) begin errors++; $display("FAIL order_owner0: got %0d want 0", FREE_NAME); end
    tick();
    drive(1'b1, 2'd0, 8'h20, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (FREE_E !== 1'b0) begin errors++; $display("FAIL order_same_cycle: got %b want 0", FREE_E); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if ({FREE_E, FREE_NAME} !== {1'b1, 2'd0}) begin errors++; $display("FAIL order_free0: got %b/%0d want 1/0", FREE_E, FREE_NAME); end
    tick();
    drive(1'b1, 2'd1, 8'h21, 1'b1, 1'b1);
    checks++; if ({FREE_E, FREE_NAME} !== {1'b0, 2'd1}) begin errors++; $display("FAIL order_wait1: got %b/%0d want 0/1", FREE_E, FREE_NAME); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if ({FREE_E, FREE_NAME} !== {1'b1, 2'd1}) begin errors++; $display("FAIL order_free1: got %b/%0d want 1/1", FREE_E, FREE_NAME); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if ({FREE_E, FREE_NAME} !== {1'b1, 2'd2}) begin errors++; $display("FAIL order_free2: got %b/%0d want 1/2", FREE_E, FREE_NAME); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if ({FREE_E, FREE_NAME} !== {1'b0, 2'd3}) begin errors++; $display("FAIL order_done: got %b/%0d want 0/3", FREE_E, FREE_NAME); end
    tick();
  endtask

  task automatic test_dup_name();
    do_reset();
    drive(1'b1, 2'd3, 8'h31, 1'b0, 1'b1); tick();
    drive(1'b1, 2'd3, 8'h32, 1'b0, 1'b1);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL dup_err_before: got %b want 0", ERR); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL dup_err: got %b want 1", ERR); end
    checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL dup_count: got %0d want 2", COUNT); end
    checks++; if ({WE_1, WE_2, WNAME_1, WNAME_2} !== {2'b11, 2'd3, 2'd3}) begin errors++; $display("FAIL dup_drain: got %b%b %0d,%0d want 11 3,3", WE_1, WE_2, WNAME_1, WNAME_2); end
    checks++; if ({WDATA_1, WDATA_2} !== {8'h31, 8'h32}) begin errors++; $display("FAIL dup_data: got %h,%h want 31,32", WDATA_1, WDATA_2); end
    tick();
    drive(1'b1, 2'd0, 8'h40, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL dup_sticky: got %b want 1", ERR); end
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL dup_count0: got %0d want 0", COUNT); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 2'd0, 8'h01, 1'b1, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    drive(1'b1, 2'd1, 8'h02, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd2, 8'h03, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 8'h04, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if ({COUNT, FREE_E, ERR} !== {3'd3, 1'b1, 1'b1}) begin errors++; $display("FAIL mid_setup: got cnt %0d free %b err %b want 3 1 1", COUNT, FREE_E, ERR); end
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    checks++; if ({WE_1, WE_2, FREE_E} !== 3'b000) begin errors++; $display("FAIL mid_outputs: got %b%b%b want 000", WE_1, WE_2, FREE_E); end
    checks++; if ({COUNT, ENQ_READY, ERR} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_state: got cnt %0d rdy %b err %b want 0 1 0", COUNT, ENQ_READY, ERR); end
    checks++; if (FREE_NAME !== 2'd0) begin errors++; $display("FAIL mid_owner: got %0d want 0", FREE_NAME); end
    tick();
  endtask

  task automatic test_random(input int cycles, input int bad_pct);
    bit            e, dr, fr, found, e_we1, e_we2;
    logic [NW-1:0] n;
    int            idx;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      e  = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 70);
      fr = ($urandom_range(0, 99) < 70);
      n  = NW'($urandom_range(0, NN - 1));
      if ($urandom_range(0, 99) >= bad_pct) begin
        found = 1'b0;
        for (int k = 0; k < NN; k++) begin
          idx = (int'(n) + k) % NN;
          if (!found && !m_pend[idx] && !m_wr[idx]) begin
            n = NW'(idx);
            found = 1'b1;
          end
        end
        if (!found || mq.size() == DEP) e = 1'b0;
      end
      drive(e, n, DW'($urandom), dr, fr);
      e_we1 = dr && (mq.size() >= 1);
      e_we2 = dr && (mq.size() >= 2);
      checks++; if ({WE_1, WE_2} !== {e_we1, e_we2}) begin errors++; $display("FAIL rand_we cyc %0d: got %b%b want %b%b", c, WE_1, WE_2, e_we1, e_we2); end
      if (e_we1) begin
        checks++; if ({WNAME_1, WDATA_1} !== {mq[0].name, mq[0].data}) begin errors++; $display("FAIL rand_port1 cyc %0d: got %0d/%h want %0d/%h", c, WNAME_1, WDATA_1, mq[0].name, mq[0].data); end
      end
      if (e_we2) begin
        checks++; if ({WNAME_2, WDATA_2} !== {mq[1].name, mq[1].data}) begin errors++; $display("FAIL rand_port2 cyc %0d: got %0d/%h want %0d/%h", c, WNAME_2, WDATA_2, mq[1].name, mq[1].data); end
      end
      checks++; if (COUNT !== CW'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d: got %0d want %0d", c, COUNT, mq.size()); end
      checks++; if (ENQ_READY !== (mq.size() != DEP)) begin errors++; $display("FAIL rand_ready cyc %0d: got %b", c, ENQ_READY); end
      checks++; if ({FREE_E, FREE_NAME} !== {m_wr[m_owner], NW'(m_owner)}) begin errors++; $display("FAIL rand_free cyc %0d: got %b/%0d want %b/%0d", c, FREE_E, FREE_NAME, m_wr[m_owner], m_owner); end
      checks++; if (ERR !== m_err) begin errors++; $display("FAIL rand_err cyc %0d: got %b want %b", c, ERR, m_err); end
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; ENQ_E = 1'b0; ENQ_NAME = '0; ENQ_DATA = '0; DRAIN_EN = 1'b0; FREE_READY = 1'b0;
    model_clear();
    test_reset();
    test_single_drain();
    test_full_drain();
    test_full_collide();
    test_free_order();
    test_dup_name();
    test_reset_mid();
    test_random(400, 0);
    test_random(400, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
